// File: rtl/tiny_rv_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate-format enum,
// decoded bundle type and small opcode classification helpers.
// Used by the decode stage and by the exec units.
package tiny_rv_pkg;

  localparam logic [6:0] RV_LUI      = 7'b0110111;
  localparam logic [6:0] RV_AUIPC    = 7'b0010111;
  localparam logic [6:0] RV_JAL      = 7'b1101111;
  localparam logic [6:0] RV_JALR     = 7'b1100111;
  localparam logic [6:0] RV_BRANCH   = 7'b1100011;
  localparam logic [6:0] RV_LOAD     = 7'b0000011;
  localparam logic [6:0] RV_STORE    = 7'b0100011;
  localparam logic [6:0] RV_OP_IMM   = 7'b0010011;
  localparam logic [6:0] RV_OP       = 7'b0110011;
  localparam logic [6:0] RV_MISC_MEM = 7'b0001111;
  localparam logic [6:0] RV_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    ImmNone,
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] imm;
    logic        illegal;
  } bundle_t;

  // Every supported opcode ends in 2'b11, so an unknown opcode also covers
  // the compressed-encoding case.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      RV_LUI, RV_AUIPC:                                 fmt = ImmU;
      RV_JAL:                                           fmt = ImmJ;
      RV_JALR, RV_LOAD, RV_OP_IMM, RV_MISC_MEM, RV_SYSTEM: fmt = ImmI;
      RV_STORE:                                         fmt = ImmS;
      RV_BRANCH:                                        fmt = ImmB;
      default:                                          fmt = ImmNone;
    endcase
    return fmt;
  endfunction

  function automatic logic is_legal(input logic [6:0] opcode);
    return (imm_fmt(opcode) != ImmNone) || (opcode == RV_OP);
  endfunction

endpackage

// File: rtl/tiny_rv_imm_gen.sv
// Combinational RV32I immediate generator.
// Ports:
//   instr_i  raw 32-bit instruction
//   imm_o    sign-extended immediate for the opcode's format (0 for R-type/illegal)
module tiny_rv_imm_gen
  import tiny_rv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (imm_fmt(instr_i[6:0]))
      ImmI: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      ImmS: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      ImmB: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
      ImmU: imm_o = {instr_i[31:12], 12'b0};
      ImmJ: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/tiny_rv_decode.sv
// RV32I decode stage with registered output bundle and a one-entry skid buffer.
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_valid/o_ready, i_pc, i_instr  fetch-side handshake and payload
//   i_flush                      drop everything held and incoming
//   o_valid/i_ready              exec-side handshake
//   o_pc .. o_illegal            decoded bundle fields
module tiny_rv_decode
  import tiny_rv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [6:0]  o_opcode,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1_idx,
  output logic [4:0]  o_rs2_idx,
  output logic [31:0] o_imm,
  output logic        o_illegal
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e  state_q, state_d;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    ready_q, ready_d;
  bundle_t dec;
  logic [31:0] imm;
  logic    in_xfer, out_xfer;

  tiny_rv_imm_gen u_imm_gen (
    .instr_i (i_instr),
    .imm_o   (imm)
  );

  always_comb begin
    dec.pc      = i_pc;
    dec.opcode  = i_instr[6:0];
    dec.funct3  = i_instr[14:12];
    dec.funct7  = i_instr[31:25];
    dec.rd      = i_instr[11:7];
    dec.rs1_idx = i_instr[19:15];
    dec.rs2_idx = i_instr[24:20];
    dec.imm     = imm;
    dec.illegal = !is_legal(i_instr[6:0]);
  end

  assign in_xfer  = i_valid && ready_q;
  assign out_xfer = (state_q != StEmpty) && i_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = StEmpty;
      out_d   = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            out_d   = dec;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_xfer && !out_xfer) begin
            skid_d  = dec;
            state_d = StFull;
          end else if (in_xfer && out_xfer) begin
            out_d   = dec;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // ready_q is low here, so no input can be accepted.
          if (out_xfer) begin
            out_d   = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    ready_d = (state_d != StFull);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = (state_q != StEmpty);
  assign o_pc      = out_q.pc;
  assign o_opcode  = out_q.opcode;
  assign o_funct3  = out_q.funct3;
  assign o_funct7  = out_q.funct7;
  assign o_rd      = out_q.rd;
  assign o_rs1_idx = out_q.rs1_idx;
  assign o_rs2_idx = out_q.rs2_idx;
  assign o_imm     = out_q.imm;
  assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_tiny_rv_decode.sv
module tb_tiny_rv_decode;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [6:0]  o_opcode;
  logic [2:0]  o_funct3;
  logic [6:0]  o_funct7;
  logic [4:0]  o_rd;
  logic [4:0]  o_rs1_idx;
  logic [4:0]  o_rs2_idx;
  logic [31:0] o_imm;
  logic        o_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [96:0] obs;
  logic [96:0] q[$];

  always #5 i_clk = ~i_clk;

  tiny_rv_decode dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_pc      (i_pc),
    .i_instr   (i_instr),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_pc      (o_pc),
    .o_opcode  (o_opcode),
    .o_funct3  (o_funct3),
    .o_funct7  (o_funct7),
    .o_rd      (o_rd),
    .o_rs1_idx (o_rs1_idx),
    .o_rs2_idx (o_rs2_idx),
    .o_imm     (o_imm),
    .o_illegal (o_illegal)
  );

  assign obs = {o_pc, o_opcode, o_funct3, o_funct7, o_rd, o_rs1_idx, o_rs2_idx, o_imm, o_illegal};

  // Reference decode: immediates built with arithmetic shifts and masks.
  function automatic logic [96:0] model(input logic [31:0] pc, input logic [31:0] ins);
    logic [6:0]  opc;
    logic [31:0] imm;
    logic        ill;
    logic signed [31:0] s;
    opc = ins[6:0];
    s   = $signed(ins);
    ill = 1'b0;
    case (opc)
      7'h37, 7'h17: imm = ins & 32'hFFFFF000;
      7'h6F: imm = (32'(s >>> 11) & 32'hFFF00000) | (ins & 32'h000FF000)
                   | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: imm = 32'(s >>> 20);
      7'h23: imm = (32'(s >>> 20) & ~32'h1F) | 32'(ins[11:7]);
      7'h63: imm = (32'(s >>> 19) & 32'hFFFFF000) | (32'(ins[7]) << 11)
                   | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      7'h33: imm = 32'h0;
      default: begin imm = 32'h0; ill = 1'b1; end
    endcase
    return {pc, opc, ins[14:12], ins[31:25], ins[11:7], ins[19:15], ins[24:20], imm, ill};
  endfunction

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_pc = '0; i_instr = '0; i_flush = 1'b0; i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_handshake: o_valid=%b o_ready=%b, required 0/1", o_valid, o_ready);
    end
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_bundle: got %h, required 0", obs);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] pcs[4]  = '{32'h0, 32'h100, 32'h200, 32'h300};
    logic [31:0] ins[4]  = '{32'h123450B7, 32'h00001117, 32'hFFF00093, 32'hFE000EE3};
    logic [31:0] imms[4] = '{32'h12345000, 32'h00001000, 32'hFFFFFFFF, 32'hFFFFFFFC};
    logic [4:0]  rds[4]  = '{5'd1, 5'd2, 5'd1, 5'd29};
    do_reset();
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_pc = pcs[k]; i_instr = ins[k];
      @(negedge i_clk);
      i_valid = 1'b0;
      n_checks++;
      if (o_valid !== 1'b1 || o_imm !== imms[k] || o_rd !== rds[k] || o_pc !== pcs[k]
          || o_illegal !== 1'b0 || o_opcode !== ins[k][6:0]) begin
        n_fail++;
        $display("FAIL vector%0d: valid=%b imm=%h rd=%0d pc=%h ill=%b opc=%b, required imm=%h rd=%0d pc=%h",
                 k, o_valid, o_imm, o_rd, o_pc, o_illegal, o_opcode, imms[k], rds[k], pcs[k]);
      end
      @(negedge i_clk);
    end
    // All-zero word is illegal but still forwarded.
    i_valid = 1'b1; i_pc = 32'h40; i_instr = 32'h0;
    @(negedge i_clk);
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || o_illegal !== 1'b1 || o_imm !== 32'h0) begin
      n_fail++;
      $display("FAIL illegal_zero: valid=%b ill=%b imm=%h, required 1/1/0", o_valid, o_illegal, o_imm);
    end
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3] = '{32'h00500113, 32'h00A00193, 32'h40208233};
    do_reset();
    i_ready = 1'b0;
    i_valid = 1'b1; i_pc = 32'h1000; i_instr = w[0];
    @(negedge i_clk);
    n_checks++;
    if (o_valid !== 1'b1 || o_ready !== 1'b1 || obs !== model(32'h1000, w[0])) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b ready=%b bundle=%h", o_valid, o_ready, obs);
    end
    i_pc = 32'h1004; i_instr = w[1];
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 1'b0 || obs !== model(32'h1000, w[0])) begin
      n_fail++;
      $display("FAIL b2b_full: ready=%b bundle=%h, required ready=0 and first bundle", o_ready, obs);
    end
    i_pc = 32'h1008; i_instr = w[2];
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || obs !== model(32'h1000, w[0])) begin
      n_fail++;
      $display("FAIL b2b_hold: ready=%b valid=%b bundle=%h", o_ready, o_valid, obs);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_valid !== 1'b1 || o_ready !== 1'b1 || obs !== model(32'h1004, w[1])) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b ready=%b bundle=%h", o_valid, o_ready, obs);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || obs !== model(32'h1008, w[2])) begin
      n_fail++;
      $display("FAIL b2b_third: valid=%b bundle=%h", o_valid, obs);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drained: o_valid=%b, required 0", o_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    i_ready = 1'b0; i_valid = 1'b1; i_pc = 32'h2000; i_instr = 32'h00100093;
    repeat (2) @(negedge i_clk);
    i_flush = 1'b1; i_pc = 32'hDEAD0000; i_instr = 32'h7FF00F93;
    @(negedge i_clk);
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: valid=%b ready=%b, required 0/1", o_valid, o_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_leak: o_valid=%b pc=%h after flush, required 0", o_valid, o_pc);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    i_ready = 1'b0; i_valid = 1'b1; i_pc = 32'h3000; i_instr = 32'h00200113;
    repeat (2) @(negedge i_clk);
    i_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || obs !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b ready=%b bundle=%h, required 0/1/0", o_valid, o_ready, obs);
    end
    @(negedge i_clk);
    i_rst = 1'b0; i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: o_valid=%b, required 0", o_valid);
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                             7'h13, 7'h33, 7'h0F, 7'h73};
    logic in_x, out_x;
    do_reset();
    q.delete();
    for (int c = 0; c < 600; c++) begin
      n_checks++;
      if (o_valid !== (q.size() > 0) || o_ready !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL rand_occupancy c%0d: valid=%b ready=%b, required held=%0d", c, o_valid,
                 o_ready, q.size());
      end
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 1) == 1);
      i_flush = ($urandom_range(0, 39) == 0);
      i_pc    = $urandom;
      i_instr = $urandom;
      if ($urandom_range(0, 3) != 0) i_instr[6:0] = opcs[$urandom_range(0, 10)];
      in_x  = i_valid && o_ready;
      out_x = o_valid && i_ready;
      if (i_flush) begin
        q.delete();
      end else begin
        if (out_x) begin
          n_checks++;
          if (obs !== q[0]) begin
            n_fail++;
            $display("FAIL rand_bundle c%0d: got %h, required %h", c, obs, q[0]);
          end
          void'(q.pop_front());
        end
        if (in_x) q.push_back(model(i_pc, i_instr));
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 5 && q.size() > 0; c++) begin
      n_checks++;
      if (o_valid !== 1'b1 || obs !== q[0]) begin
        n_fail++;
        $display("FAIL drain_bundle: valid=%b got %h, required %h", o_valid, obs, q[0]);
      end
      void'(q.pop_front());
      @(negedge i_clk);
    end
    n_checks++;
    if (q.size() != 0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_end: %0d bundles left, o_valid=%b, required 0/0", q.size(), o_valid);
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tiny_rv_decode.md
TINY_RV_DECODE -- requirements
Module: tiny_rv_decode

Interface
REQ-001 i_clk  input  1  single core clock; all state on rising edge.
REQ-002 i_rst  input  1  reset, asynchronous and active-high.
REQ-003 i_valid  input  1  fetch side: i_pc/i_instr valid.
REQ-004 o_ready  output  1  decode accepts a fetch word this cycle; driven from a flop.
REQ-005 i_pc  input  32  PC of fetched word.
REQ-006 i_instr  input  32  raw RV32I instruction.
REQ-007 i_flush  input  1  discard all held and incoming instructions.
REQ-008 o_valid  output  1  decoded bundle valid toward exec units.
REQ-009 i_ready  input  1  exec side accepts the bundle.
REQ-010 o_pc  output  32  PC of bundle.
REQ-011 o_opcode  output  7  instr[6:0].
REQ-012 o_funct3  output  3  instr[14:12].
REQ-013 o_funct7  output  7  instr[31:25].
REQ-014 o_rd, o_rs1_idx, o_rs2_idx  output  5 each  instr[11:7], [19:15], [24:20].
REQ-015 o_imm  output  32  sign-extended immediate for the opcode's format.
REQ-016 o_illegal  output  1  opcode not in the supported set, or instr[1:0] != 2'b11.

Function
REQ-017 Transfer in occurs when i_valid && o_ready; transfer out occurs when o_valid && i_ready.
REQ-018 Output stage is a registered bundle: latency from input transfer to o_valid is exactly 1 cycle when the output stage is empty or draining.
REQ-019 A one-entry skid buffer holds a decoded bundle accepted while the output is stalled; o_ready = !skid_full, registered.
REQ-020 States: EMPTY (out invalid), ONE (out valid, skid empty), FULL (out valid, skid full).
REQ-021 EMPTY: input transfer -> ONE. ONE: input without output transfer -> FULL; output without input -> EMPTY; both -> ONE with new bundle. FULL: output transfer moves skid to output -> ONE; no input accepted.
REQ-022 Bundle order is strictly preserved; no bundle is dropped or duplicated absent i_flush.
REQ-023 Immediates: I = sext(instr[31:20]); S = sext({[31:25],[11:7]}); B = sext({[31],[7],[30:25],[11:8],0}); U = {[31:12],12'b0}; J = sext({[31],[19:12],[20],[30:21],0}).
REQ-024 Format map: LUI/AUIPC -> U; JAL -> J; JALR/LOAD/OP-IMM/MISC-MEM/SYSTEM -> I; STORE -> S; BRANCH -> B; OP and illegal -> imm 0.
REQ-025 Illegal instructions are still passed through as bundles with o_illegal=1; decode does not trap.
REQ-026 i_flush: next state EMPTY, o_valid=0 next cycle, skid cleared, any i_valid in the same cycle discarded; flush has priority over all transfers.
REQ-027 Bundle fields are held stable while o_valid && !i_ready.

Reset
REQ-028 On i_rst: state EMPTY, o_valid=0, o_ready=1, all bundle outputs 0, skid cleared, asynchronously.
REQ-029 Reset asserted mid-transfer discards the in-flight and skid bundles; first post-reset accept requires a fresh i_valid.

Structure
REQ-030 Opcode constants (RV_LUI, RV_AUIPC, RV_JAL, RV_JALR, RV_BRANCH, RV_LOAD, RV_STORE, RV_OP_IMM, RV_OP, RV_MISC_MEM, RV_SYSTEM) and an immediate-format enum live in shared package tiny_rv_pkg, also used by the exec units.
REQ-031 Immediate generation is a combinational sub-module tiny_rv_imm_gen (instr in, imm out).

Verification
REQ-032 i_instr=0x123450B7, pc=0x0 -> next cycle o_valid=1, opcode=0110111, o_rd=1, o_imm=0x12345000, o_illegal=0.
REQ-033 i_instr=0x00001117, pc=0x100 -> o_rd=2, o_imm=0x00001000, o_pc=0x100.
REQ-034 i_instr=0xFFF00093 -> o_imm=0xFFFFFFFF; i_instr=0xFE000EE3 -> o_imm=0xFFFFFFFC.
REQ-035 i_ready=0 with three back-to-back inputs -> first in output, second in skid, o_ready=0 on third; release i_ready -> three bundles emitted in order, none lost.
REQ-036 i_instr=0x00000000 -> o_valid=1, o_illegal=1, o_imm=0.
REQ-037 State FULL plus i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, incoming word never appears at output.
